pipeline_wb_unit: RTL and testbench
===================================

// Module: pipeline_wb_unit
// PURPOSE
//   Registered write-back stage for the pipelined CPU, sitting between MEM and the register file.
//   Selects the result from ALU, load data, PC+step or immediate, and sign/zero-extends sub-word loads.
//   Absorbs late memory responses with a wait state and back-pressure.
//   Issues one registered register-file write per retired instruction.
// PARAMETERS
//   XLEN     32  datapath width (>=32, multiple of 8)
//   PC_STEP  4   increment added to pc for link writes
//   CNT_W    32  retire counter width (WB_RETIRE_CNT_EN only)
// PORTS
//   clk         in   1     clock; all state updates on rising edge
//   rst_n       in   1     synchronous reset, active-low
//   in_valid    in   1     MEM stage presents an instruction
//   in_ready    out  1     stage can accept; = (state==IDLE) & rst_n
//   flush       in   1     discard accepted/pending instruction
//   alu_res     in   XLEN  ALU result
//   mem_rdata   in   XLEN  load data, valid when mem_rvalid=1
//   mem_rvalid  in   1     load data valid this cycle
//   pc          in   XLEN  instruction PC
//   imm         in   XLEN  immediate (LUI path)
//   memto_reg   in   3     000 ALU, 001 MEM, 010 PC+PC_STEP, 011 IMM, others ALU
//   load_type   in   3     000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011/110/111 -> LW
//   addr_lo     in   2     load byte offset
//   rd          in   5     destination register
//   reg_write   in   1     instruction writes rd
//   wb_en       out  1     register-file write strobe, one-cycle pulse
//   wb_rd       out  5     write address
//   wb_data     out  XLEN  write data
//   retire_cnt  out  CNT_W retired count (WB_RETIRE_CNT_EN only)
// BEHAVIOUR
//   - Reset (rst_n=0 at edge): state=IDLE, wb_en=0, wb_rd=0, wb_data=0, captured fields=0,
//     retire_cnt=0. Reset mid-WAIT_MEM drops the pending load, producing no write.
//   - Accept = in_valid & in_ready & !flush.
//   - FSM IDLE: on accept with memto_reg!=001, or memto_reg==001 & mem_rvalid,
//     commit: wb_* registered at the next edge (latency 1).
//     On accept with memto_reg==001 & !mem_rvalid: capture pc/imm/alu_res/load_type/addr_lo/rd/reg_write,
//     then go to WAIT_MEM.
//   - FSM WAIT_MEM: in_ready=0. On mem_rvalid & !flush: commit using captured fields and go to IDLE.
//     On flush: go to IDLE with no write (flush wins over simultaneous mem_rvalid).
//     Inputs other than mem_rdata/mem_rvalid/flush are ignored.
//   - Commit: wb_en <= reg_write & (rd!=0), wb_rd <= rd, wb_data <= selected value.
//     If wb_en=0, wb_rd/wb_data still update.
//     Non-commit cycles: wb_en <= 0; wb_rd/wb_data hold their values.
//   - Load extract: byte = mem_rdata[8*addr_lo +: 8]; half = mem_rdata[16*addr_lo[1] +: 16]
//     (addr_lo[0] ignored). LB/LH sign-extend; LBU/LHU zero-extend to XLEN.
//     LW passes the low XLEN bits unchanged.
//   - PC path: pc + PC_STEP modulo 2^XLEN (wraps; no carry out).
//   - No throughput loss: back-to-back non-stalled accepts commit every cycle.
// CONFIGURATION
//   WB_RETIRE_CNT_EN defined: retire_cnt increments by 1 on each commit (including rd==0
//     or reg_write=0) and wraps at 2^CNT_W. Flushed or reset-dropped instructions do not count.
//   WB_RETIRE_CNT_EN undefined: retire_cnt port and counter absent; all other behaviour identical.
// TESTING
//   1 ALU: memto_reg=000, alu_res=0x1234, rd=5, reg_write=1 -> next cycle wb_en=1, wb_rd=5, wb_data=0x1234.
//   2 LB sign: mem_rdata=0x0000_8000, addr_lo=1, load_type=000, mem_rvalid=1 -> wb_data=0xFFFF_FF80.
//     Same stimulus with LBU -> wb_data=0x0000_0080.
//   3 Late load: memto_reg=001, mem_rvalid=0 for 3 cycles -> in_ready=0 for 3 cycles.
//     mem_rvalid=1 with 0xA5 -> wb_en pulse next cycle with wb_data=0xA5; in_ready=1 again.
//   4 Flush+rvalid: in WAIT_MEM, flush=1 and mem_rvalid=1 in the same cycle
//     -> no wb_en, state=IDLE, retire_cnt unchanged.
//   5 Link wrap: memto_reg=010, pc=0xFFFF_FFFC -> wb_data=0x0000_0000.
//     With rd=0: wb_en=0, retire_cnt +1.
//   6 Reset during WAIT_MEM: rst_n=0 one edge, then mem_rvalid=1 -> no wb_en, wb_data=0, in_ready=1.

Source files
------------

// File: rtl/pipeline_wb_unit.sv
// rtl/pipeline_wb_unit.sv - registered write-back stage with late-load wait state
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module pipeline_wb_unit #(
  parameter int XLEN    = 32,
  parameter int PC_STEP = 4,
  parameter int CNT_W   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [XLEN-1:0] alu_res,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [2:0]      memto_reg,
  input  logic [2:0]      load_type,
  input  logic [1:0]      addr_lo,
  input  logic [4:0]      rd,
  input  logic            reg_write,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retire_cnt
`endif
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] cap_pc_q, cap_pc_d, cap_imm_q, cap_imm_d, cap_alu_q, cap_alu_d;
  logic [2:0]      cap_lt_q, cap_lt_d;
  logic [1:0]      cap_al_q, cap_al_d;
  logic [4:0]      cap_rd_q, cap_rd_d;
  logic            cap_rw_q, cap_rw_d;
  logic            wb_en_q, wb_en_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            accept, commit;

  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] rdata,
                                               input logic [2:0] lt, input logic [1:0] al);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[8*al +: 8];
    h = rdata[16*al[1] +: 16];
    case (lt)
      3'b000:  return {{(XLEN-8){b[7]}}, b};
      3'b001:  return {{(XLEN-16){h[15]}}, h};
      3'b100:  return {{(XLEN-8){1'b0}}, b};
      3'b101:  return {{(XLEN-16){1'b0}}, h};
      default: return rdata;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] select(input logic [2:0] sel, input logic [XLEN-1:0] alu,
                                             input logic [XLEN-1:0] rdata, input logic [XLEN-1:0] pcv,
                                             input logic [XLEN-1:0] immv, input logic [2:0] lt,
                                             input logic [1:0] al);
    case (sel)
      3'b001:  return load_ext(rdata, lt, al);
      3'b010:  return pcv + XLEN'(PC_STEP);
      3'b011:  return immv;
      default: return alu;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign in_ready = (state_q == IDLE) & rst_n;
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept && memto_reg == 3'b001 && !mem_rvalid) state_d = WAIT_MEM;
      WAIT_MEM: if (flush || mem_rvalid) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    commit    = 1'b0;
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    cap_pc_d  = cap_pc_q;
    cap_imm_d = cap_imm_q;
    cap_alu_d = cap_alu_q;
    cap_lt_d  = cap_lt_q;
    cap_al_d  = cap_al_q;
    cap_rd_d  = cap_rd_q;
    cap_rw_d  = cap_rw_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (memto_reg == 3'b001 && !mem_rvalid) begin
            cap_pc_d  = pc;
            cap_imm_d = imm;
            cap_alu_d = alu_res;
            cap_lt_d  = load_type;
            cap_al_d  = addr_lo;
            cap_rd_d  = rd;
            cap_rw_d  = reg_write;
          end else begin
            commit    = 1'b1;
            wb_en_d   = reg_write & (rd != 5'd0);
            wb_rd_d   = rd;
            wb_data_d = select(memto_reg, alu_res, mem_rdata, pc, imm, load_type, addr_lo);
          end
        end
      end
      WAIT_MEM: begin
        // Flush takes priority: a squashed load never reaches the register file.
        if (mem_rvalid && !flush) begin
          commit    = 1'b1;
          wb_en_d   = cap_rw_q & (cap_rd_q != 5'd0);
          wb_rd_d   = cap_rd_q;
          wb_data_d = select(3'b001, cap_alu_q, mem_rdata, cap_pc_q, cap_imm_q, cap_lt_q, cap_al_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      cap_pc_q  <= '0;
      cap_imm_q <= '0;
      cap_alu_q <= '0;
      cap_lt_q  <= '0;
      cap_al_q  <= '0;
      cap_rd_q  <= '0;
      cap_rw_q  <= 1'b0;
    end else begin
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      cap_pc_q  <= cap_pc_d;
      cap_imm_q <= cap_imm_d;
      cap_alu_q <= cap_alu_d;
      cap_lt_q  <= cap_lt_d;
      cap_al_q  <= cap_al_d;
      cap_rd_q  <= cap_rd_d;
      cap_rw_q  <= cap_rw_d;
    end
  end

  assign wb_en   = wb_en_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  always_comb retire_cnt_d = commit ? retire_cnt_q + CNT_W'(1) : retire_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) retire_cnt_q <= '0;
    else        retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_wb_unit.sv
// tb/tb_pipeline_wb_unit.sv - randomized bench for pipeline_wb_unit against a behavioural model
// Retire counter checks are compiled in when WB_RETIRE_CNT_EN is defined.
module tb_pipeline_wb_unit;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, mem_rvalid, reg_write;
  logic [31:0] alu_res, mem_rdata, pc, imm;
  logic [2:0]  memto_reg, load_type;
  logic [1:0]  addr_lo;
  logic [4:0]  rd;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  always #5 clk = ~clk;

  pipeline_wb_unit #(.XLEN(32), .PC_STEP(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .alu_res(alu_res), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .pc(pc), .imm(imm),
    .memto_reg(memto_reg), .load_type(load_type), .addr_lo(addr_lo), .rd(rd),
    .reg_write(reg_write), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one optional outstanding load, plus the last write seen.
  bit          m_pend = 1'b0;
  logic [31:0] p_alu, p_pc, p_imm;
  logic [2:0]  p_lt;
  logic [1:0]  p_al;
  logic [4:0]  p_rd;
  logic        p_rw;
  logic        e_en   = 1'b0;
  logic [4:0]  e_rd   = '0;
  logic [31:0] e_data = '0;
  logic [31:0] m_cnt  = '0;

  function automatic logic [31:0] m_load(input logic [31:0] d, input logic [2:0] lt,
                                         input logic [1:0] al);
    logic [31:0] b, h;
    b = (d >> (8 * al)) & 32'hFF;
    h = (d >> (al[1] ? 16 : 0)) & 32'hFFFF;
    case (lt)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_result(input logic [2:0] sel, input logic [31:0] a,
                                           input logic [31:0] d, input logic [31:0] p,
                                           input logic [31:0] im, input logic [2:0] lt,
                                           input logic [1:0] al);
    if (sel == 3'd1) return m_load(d, lt, al);
    if (sel == 3'd2) return p + 32'd4;
    if (sel == 3'd3) return im;
    return a;
  endfunction

  task automatic m_retire(input logic [4:0] r, input logic w, input logic [31:0] v);
    e_en   = w && (r != 0);
    e_rd   = r;
    e_data = v;
    m_cnt  = m_cnt + 1;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pend = 1'b0;
      e_en = 1'b0; e_rd = '0; e_data = '0; m_cnt = '0;
    end else begin
      e_en = 1'b0;
      if (m_pend) begin
        if (flush) m_pend = 1'b0;
        else if (mem_rvalid) begin
          m_retire(p_rd, p_rw, m_result(3'd1, p_alu, mem_rdata, p_pc, p_imm, p_lt, p_al));
          m_pend = 1'b0;
        end
      end else if (in_valid && !flush) begin
        if (memto_reg == 3'd1 && !mem_rvalid) begin
          m_pend = 1'b1;
          p_alu = alu_res; p_pc = pc; p_imm = imm;
          p_lt = load_type; p_al = addr_lo; p_rd = rd; p_rw = reg_write;
        end else begin
          m_retire(rd, reg_write, m_result(memto_reg, alu_res, mem_rdata, pc, imm, load_type, addr_lo));
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        chk("wb_en", {31'd0, wb_en}, {31'd0, e_en});
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e_rd});
        chk("wb_data", wb_data, e_data);
        chk("in_ready", {31'd0, in_ready}, {31'd0, (rst_n && !m_pend)});
`ifdef WB_RETIRE_CNT_EN
        chk("retire_cnt", retire_cnt, m_cnt);
`endif
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    in_valid = 1'b0; flush = 1'b0; mem_rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; idle();
    alu_res = '0; mem_rdata = '0; pc = '0; imm = '0;
    memto_reg = '0; load_type = '0; addr_lo = '0; rd = '0; reg_write = 1'b0;
    step(); step();
    checking = 1'b1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst_n = 1'b1;

    // ALU write, then two back-to-back sub-word loads
    in_valid = 1'b1; memto_reg = 3'd0; alu_res = 32'h1234; rd = 5'd5; reg_write = 1'b1;
    step();
    chk("t1_en", {31'd0, wb_en}, 32'd1);
    chk("t1_rd", {27'd0, wb_rd}, 32'd5);
    chk("t1_data", wb_data, 32'h1234);
    memto_reg = 3'd1; mem_rdata = 32'h0000_8000; addr_lo = 2'd1; load_type = 3'd0;
    mem_rvalid = 1'b1; rd = 5'd3;
    step();
    chk("t2_lb", wb_data, 32'hFFFF_FF80);
    chk("t2_lb_en", {31'd0, wb_en}, 32'd1);
    load_type = 3'd4;
    step();
    chk("t2_lbu", wb_data, 32'h0000_0080);
    idle(); step();

    // Late load: live fields during the wait must be ignored
    in_valid = 1'b1; memto_reg = 3'd1; mem_rvalid = 1'b0; load_type = 3'd2; addr_lo = 2'd0;
    rd = 5'd7; reg_write = 1'b1;
    step();
    chk("t3_ready0", {31'd0, in_ready}, 32'd0);
    load_type = 3'd0; memto_reg = 3'd0; rd = 5'd9;
    step();
    chk("t3_ready1", {31'd0, in_ready}, 32'd0);
    step();
    chk("t3_ready2", {31'd0, in_ready}, 32'd0);
    chk("t3_no_en", {31'd0, wb_en}, 32'd0);
    in_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_00A5;
    step();
    chk("t3_en", {31'd0, wb_en}, 32'd1);
    chk("t3_rd", {27'd0, wb_rd}, 32'd7);
    chk("t3_data", wb_data, 32'h0000_00A5);
    chk("t3_ready", {31'd0, in_ready}, 32'd1);
    idle(); step();

    // Flush wins over a simultaneous load response
    in_valid = 1'b1; memto_reg = 3'd1; mem_rvalid = 1'b0; rd = 5'd9;
    step();
    in_valid = 1'b0; flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF;
    step();
    chk("t4_no_en", {31'd0, wb_en}, 32'd0);
    chk("t4_ready", {31'd0, in_ready}, 32'd1);
    idle(); step();
    chk("t4_still_no_en", {31'd0, wb_en}, 32'd0);

    // Link wrap to rd=0, then a normal link
    in_valid = 1'b1; memto_reg = 3'd2; pc = 32'hFFFF_FFFC; rd = 5'd0; reg_write = 1'b1;
    step();
    chk("t5_wrap", wb_data, 32'h0000_0000);
    chk("t5_rd0_en", {31'd0, wb_en}, 32'd0);
    pc = 32'h100; rd = 5'd1;
    step();
    chk("t5_link", wb_data, 32'h104);
    chk("t5_link_en", {31'd0, wb_en}, 32'd1);

    // Reset while a load is pending drops it
    memto_reg = 3'd1; mem_rvalid = 1'b0; rd = 5'd4;
    step();
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234;
    step();
    chk("t6_no_en", {31'd0, wb_en}, 32'd0);
    chk("t6_data", wb_data, 32'd0);
    chk("t6_ready", {31'd0, in_ready}, 32'd1);
    idle(); step();

    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      in_valid   = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 9) == 0);
      mem_rvalid = $urandom_range(0, 1) == 1;
      alu_res    = $urandom;
      mem_rdata  = $urandom;
      pc         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      imm        = $urandom;
      memto_reg  = ($urandom_range(0, 2) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
      load_type  = 3'($urandom_range(0, 7));
      addr_lo    = 2'($urandom_range(0, 3));
      rd         = 5'($urandom_range(0, 31));
      reg_write  = $urandom_range(0, 3) != 0;
      step();
    end
    rst_n = 1'b1; idle();
    step(); step();
    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
